// File: rtl/instr_fetch_assembler.sv
// rtl/instr_fetch_assembler.sv - byte-wide instruction fetch, assembles 32-bit words for decode
// Optional: FETCH_ISA_ID_EN diverts the first word after reset / redirect-to-0 into isa_id.
module instr_fetch_assembler #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [7:0]        ic_in,
    input  logic [1:0]        lane_in,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_word,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              lane_err
`ifdef FETCH_ISA_ID_EN
    ,
    output logic [31:0]       isa_id
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] START_PC   = RESET_PC & ALIGN_MASK;

    typedef enum logic {FETCH, HOLD} state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic [ADDR_W-1:0] target_aligned;
`ifdef FETCH_ISA_ID_EN
    logic              first_q;
`endif

    assign target_aligned = branch_target & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_out      <= START_PC;
            byte_cnt    <= 2'd0;
            asm_q       <= 24'd0;
            instr_valid <= 1'b0;
            instr_word  <= 32'd0;
            instr_pc    <= '0;
            lane_err    <= 1'b0;
`ifdef FETCH_ISA_ID_EN
            isa_id      <= 32'd0;
            first_q     <= 1'b1;
`endif
        end else begin
            // Lane mismatch is only a diagnostic; capture continues regardless.
            if (state == FETCH && lane_in != byte_cnt)
                lane_err <= 1'b1;

            if (branch_valid) begin
                pc_out      <= target_aligned;
                byte_cnt    <= 2'd0;
                asm_q       <= 24'd0;
                instr_valid <= 1'b0;
                state       <= FETCH;
`ifdef FETCH_ISA_ID_EN
                first_q     <= (target_aligned == '0);
`endif
            end else begin
                case (state)
                    FETCH: begin
                        pc_out   <= pc_out + ADDR_W'(1);
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= ic_in;
                            2'd1: asm_q[15:8]  <= ic_in;
                            2'd2: asm_q[23:16] <= ic_in;
                            default: begin
`ifdef FETCH_ISA_ID_EN
                                if (first_q) begin
                                    isa_id  <= {ic_in, asm_q};
                                    first_q <= 1'b0;
                                end else begin
                                    instr_word  <= {ic_in, asm_q};
                                    instr_pc    <= pc_out - ADDR_W'(3);
                                    instr_valid <= 1'b1;
                                    state       <= HOLD;
                                end
`else
                                instr_word  <= {ic_in, asm_q};
                                instr_pc    <= pc_out - ADDR_W'(3);
                                instr_valid <= 1'b1;
                                state       <= HOLD;
`endif
                            end
                        endcase
                    end
                    HOLD: begin
                        if (instr_valid && instr_ready) begin
                            instr_valid <= 1'b0;
                            state       <= FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule
